// File: rtl/mem_write_checker.sv
// mem_write_checker
// Self-check monitor for the CPU data-memory write port. A table of expected
// (address, data) writes is loaded while idle. A run then compares bus writes
// against the table in order, and the block reports pass, fail or timeout
// together with diagnostics.
module mem_write_checker #(
   parameter  int ADDR_W      = 32,
   parameter  int DATA_W      = 32,
   parameter  int NUM_EXP     = 4,
   parameter  int TIMEOUT_CYC = 1000,
   parameter  int MODE        = 0,
   localparam int IDX_W       = (NUM_EXP > 1) ? $clog2(NUM_EXP) : 1,
   localparam int CNT_W       = $clog2(NUM_EXP + 1)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              exp_we,
   input  logic [IDX_W-1:0]  exp_idx,
   input  logic [ADDR_W-1:0] exp_addr,
   input  logic [DATA_W-1:0] exp_data,
   input  logic [CNT_W-1:0]  num_exp,
   input  logic              start,
   input  logic              memwrite,
   input  logic [ADDR_W-1:0] dataadr,
   input  logic [DATA_W-1:0] writedata,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic              fail,
   output logic              timeout,
   output logic [CNT_W-1:0]  match_cnt,
   output logic [ADDR_W-1:0] err_addr,
   output logic [DATA_W-1:0] err_data,
   output logic [31:0]       cycle_cnt
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_PASS = 2'd2;
   localparam logic [1:0] S_FAIL = 2'd3;

   logic [1:0]        r_state;
   logic [CNT_W-1:0]  r_n;
   logic [CNT_W-1:0]  r_match_cnt;
   logic [31:0]       r_cycle_cnt;
   logic [ADDR_W-1:0] r_err_addr;
   logic [DATA_W-1:0] r_err_data;
   logic              r_timeout;
   logic [ADDR_W-1:0] r_exp_addr [NUM_EXP];
   logic [DATA_W-1:0] r_exp_data [NUM_EXP];

   logic              w_idx_ok;
   logic [CNT_W-1:0]  w_num_clamp;
   logic [IDX_W-1:0]  w_cur_idx;
   logic [CNT_W-1:0]  w_match_nxt;
   logic              w_hit;
   logic              w_complete;
   logic              w_mismatch;
   logic              w_tmo;

   assign w_idx_ok    = 32'(exp_idx) < 32'(NUM_EXP);
   assign w_num_clamp = (num_exp > CNT_W'(NUM_EXP)) ? CNT_W'(NUM_EXP) : num_exp;
   // match_cnt stays below N (<= NUM_EXP) while running, so truncation is safe
   assign w_cur_idx   = IDX_W'(r_match_cnt);
   assign w_match_nxt = r_match_cnt + CNT_W'(1);
   assign w_hit       = memwrite && (dataadr == r_exp_addr[w_cur_idx])
                                 && (writedata == r_exp_data[w_cur_idx]);
   assign w_complete  = w_hit && (w_match_nxt == r_n);
   assign w_mismatch  = memwrite && !w_hit;
   assign w_tmo       = (TIMEOUT_CYC != 0) && (r_cycle_cnt == 32'(TIMEOUT_CYC - 1));

   // Expected-value table: writable whenever no run is in progress
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < NUM_EXP; i++) begin
            r_exp_addr[i] <= '0;
            r_exp_data[i] <= '0;
         end
      end else if (exp_we && (r_state != S_RUN) && w_idx_ok) begin
         r_exp_addr[exp_idx] <= exp_addr;
         r_exp_data[exp_idx] <= exp_data;
      end
   end

   // Run control: start handling, in-order matching, mismatch and timeout
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= S_IDLE;
         r_n         <= '0;
         r_match_cnt <= '0;
         r_cycle_cnt <= '0;
         r_err_addr  <= '0;
         r_err_data  <= '0;
         r_timeout   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_PASS, S_FAIL: begin
               if (start) begin
                  r_match_cnt <= '0;
                  r_cycle_cnt <= '0;
                  r_err_addr  <= '0;
                  r_err_data  <= '0;
                  r_timeout   <= 1'b0;
                  r_n         <= w_num_clamp;
                  r_state     <= (w_num_clamp == '0) ? S_PASS : S_RUN;
               end
            end
            S_RUN: begin
               if (r_cycle_cnt != '1) r_cycle_cnt <= r_cycle_cnt + 32'd1;
               if (w_hit) r_match_cnt <= w_match_nxt;
               // a completing match outranks a timeout in the same cycle
               if (w_complete) begin
                  r_state <= S_PASS;
               end else if (w_mismatch && (MODE == 0)) begin
                  r_state    <= S_FAIL;
                  r_err_addr <= dataadr;
                  r_err_data <= writedata;
               end else if (w_tmo) begin
                  r_state   <= S_FAIL;
                  r_timeout <= 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy      = (r_state == S_RUN);
   assign pass      = (r_state == S_PASS);
   assign fail      = (r_state == S_FAIL);
   assign done      = pass || fail;
   assign timeout   = r_timeout;
   assign match_cnt = r_match_cnt;
   assign err_addr  = r_err_addr;
   assign err_data  = r_err_data;
   assign cycle_cnt = r_cycle_cnt;

endmodule
